i2s_tx_scheduler: RTL and testbench
===================================

# i2s_tx_scheduler

Stereo frame scheduler that drives the serial I2S link (`SD`, `WS`, `in_valid`) consumed by the team's I2S receiver. It accepts left and right 32-bit samples from two independent requesters over valid/ready handshakes and buffers one sample per channel. It launches a stereo frame only when both samples are present, serialises it MSB-first with correct word-select framing, and enforces an inter-frame gap so the receiver can present its output.

## Interface

- `GAP`, default 2: number of GAP-state cycles after each frame; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when 1, frames may launch; when 0, no new frame launches and the current frame completes.
- `l_valid`  in  1  left sample offered.
- `l_data`  in  32  left sample.
- `l_ready`  out  1  left slot empty.
- `r_valid`  in  1  right sample offered.
- `r_data`  in  32  right sample.
- `r_ready`  out  1  right slot empty.
- `in_valid`  out  1  serial word active, to the receiver.
- `SD`  out  1  serial data, MSB first.
- `WS`  out  1  word select: 0 = left, 1 = right.
- `busy`  out  1  state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse, registered, on entry to GAP.

## Operation

- **Reset values:** all outputs are 0 except `l_ready` and `r_ready`, which are 1. Both slots are empty, state = IDLE, and all counters are 0.
- **Slots:** each slot holds one 32-bit word and a `full` flag. `x_ready = !x_full`.
  - A handshake occurs when `x_valid & x_ready` at a posedge. The data is captured and `full` is set.
  - Accept and free never coincide on one slot.
- **States:** IDLE, LEFT, RIGHT, GAP.
- **IDLE → LEFT:** taken when `enable & l_full & r_full`.
  - `shift <= l_slot`; `l_full <= 0`.
  - `in_valid <= 1`; `WS <= 0`; `SD <= l_slot[31]`; `bit_cnt <= 31`.
- **LEFT:** on each edge, `bit_cnt` decrements and `SD` presents the next bit.
  - When `bit_cnt == 0`, go to RIGHT.
  - On that edge: `shift <= r_slot`; `r_full <= 0`; `WS <= 1`; `SD <= r_slot[31]`; `bit_cnt <= 31`.
- **RIGHT:** behaves as LEFT. When `bit_cnt == 0`, go to GAP.
  - On that edge: `in_valid <= 0`; `WS <= 0`; `SD <= 0`; `gap_cnt <= GAP-1`; `frame_done <= 1`.
- **GAP:** `gap_cnt` decrements. When `gap_cnt == 0`, go to IDLE.
- **Idle outputs:** in IDLE and GAP, `in_valid`, `WS` and `SD` are 0.
- **Refill:** slots may refill while a frame is in flight. The left slot frees at LEFT entry, the right slot at RIGHT entry.
- **`enable` deassertion:** sampled only in IDLE. Deasserting mid-frame has no effect until the frame and its GAP finish.
- **Partial data:** one slot full and the other empty holds in IDLE indefinitely. There is no timeout and no mono mode.
- **Reset mid-frame:** asserting `rst_n` low mid-frame drops both the frame and the slot contents immediately. Outputs take their reset values asynchronously.

## Timing

- **Launch latency:** both slots full at edge k gives `in_valid`=1 and `SD`=L[31] after edge k+1.
- **Frame length:** `in_valid` is high for exactly 64 cycles: 32 with `WS`=0, then 32 with `WS`=1.
- **WS toggle:** `WS` toggles on the same edge as the first right bit.
- **Inter-frame gap:** `in_valid` is low for at least GAP+1 cycles (GAP cycles in GAP plus 1 in IDLE). This ≥2-cycle gap satisfies the receiver's output cycle.
- **Maximum throughput:** one frame per 64+GAP+1 cycles.
- **`frame_done`:** high for the first GAP cycle only.
- **Output registers:** all serial outputs are registered, with no combinational path from inputs. `x_ready` is a direct flop output.

## Structure

- **Package `i2s_pkg`:**
  - `WORD_W = 32`.
  - `typedef enum logic [1:0] {IDLE, LEFT, RIGHT, GAP} i2s_tx_state_e`.
  - `BITCNT_W = 5`.
- **Sub-module `i2s_tx_slot`:** one-entry valid/ready holding register with a `free` input. It is instantiated twice, once for left and once for right.
- **Top level:** the FSM, shift register, `bit_cnt`, `gap_cnt` and output flops live in `i2s_tx_scheduler`.

## Test plan

- **Single frame:**
  - Stimulus: L=32'h8000_0001, R=32'hA5A5_5A5A.
  - Required: `SD` shows 1,0×30,1 with `WS`=0, then the A5A55A5A bits MSB-first with `WS`=1. `in_valid` is high for 64 cycles and `frame_done` pulses once.
- **Back-to-back:**
  - Stimulus: refill both slots during the frame, with GAP=2.
  - Required: `in_valid` is low exactly 3 cycles between frames. `l_ready` falls one cycle after LEFT entry refill and `r_ready` similarly.
- **Late right sample:**
  - Stimulus: L accepted at cycle 0, R at cycle 20.
  - Required: `in_valid` stays 0 until cycle 21, then rises. `l_ready` stays 0 throughout the wait.
- **Enable drop:**
  - Stimulus: deassert `enable` at bit 10 of LEFT while the next pair is already buffered.
  - Required: the current frame completes all 64 bits, with no launch while `enable`=0. Reasserting `enable` gives a launch next cycle.
- **Reset mid-RIGHT:**
  - Stimulus: assert `rst_n` low mid-RIGHT.
  - Required: `in_valid`, `SD`, `WS`, `busy` go 0 immediately and `l_ready`/`r_ready` go 1. After release, no frame launches until new data arrives.
- **Loopback:**
  - Stimulus: 100 random stereo pairs through the receiver.
  - Required: each `out_left`/`out_right` matches the sent pair in order.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared widths and state encoding for the I2S stereo transmit scheduler.
package i2s_pkg;
    localparam int WORD_W   = 32;
    localparam int BITCNT_W = 5;
    localparam int GAPCNT_W = 4;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, GAP} i2s_tx_state_e;
endpackage

// File: rtl/i2s_tx_slot.sv
// One-entry valid/ready sample holder; accepts when empty, empties on free_i.
// ready_o is a flop output, so upstream sees no combinational path through this slot.
module i2s_tx_slot
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              ready_o,
    input  logic              free_i,
    output logic              full_o,
    output logic [WORD_W-1:0] data_o
);
    logic              ready_q, ready_d;
    logic [WORD_W-1:0] data_q, data_d;

    // free_i only arrives while full, so it can never collide with an accept.
    always_comb begin
        ready_d = ready_q;
        data_d  = data_q;
        if (valid_i && ready_q) begin
            ready_d = 1'b0;
            data_d  = data_i;
        end else if (free_i) begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
            data_q  <= '0;
        end else begin
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = ready_q;
    assign full_o  = !ready_q;
    assign data_o  = data_q;
endmodule

// File: rtl/i2s_tx_scheduler.sv
// Stereo I2S frame scheduler: launches 64-bit L/R frame one cycle after both slots fill, then GAP idle cycles.
// Slots refill mid-frame (left at LEFT entry, right at RIGHT entry); all serial outputs are registered.
module i2s_tx_scheduler #(
    parameter int unsigned GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       l_valid,
    input  logic [i2s_pkg::WORD_W-1:0] l_data,
    output logic                       l_ready,
    input  logic                       r_valid,
    input  logic [i2s_pkg::WORD_W-1:0] r_data,
    output logic                       r_ready,
    output logic                       in_valid,
    output logic                       SD,
    output logic                       WS,
    output logic                       busy,
    output logic                       frame_done
);
    import i2s_pkg::*;

    i2s_tx_state_e       state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAPCNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                in_valid_q, in_valid_d;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic                frame_done_q, frame_done_d;

    logic                l_full, r_full, l_free, r_free;
    logic [WORD_W-1:0]   l_slot, r_slot;

    i2s_tx_slot u_l_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (l_valid),
        .data_i  (l_data),
        .ready_o (l_ready),
        .free_i  (l_free),
        .full_o  (l_full),
        .data_o  (l_slot)
    );

    i2s_tx_slot u_r_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (r_valid),
        .data_i  (r_data),
        .ready_o (r_ready),
        .free_i  (r_free),
        .full_o  (r_full),
        .data_o  (r_slot)
    );

    // The shift register is loaded pre-shifted by one: the MSB goes straight to SD on the load edge.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        in_valid_d   = in_valid_q;
        ws_d         = ws_q;
        sd_d         = sd_q;
        frame_done_d = 1'b0;
        l_free       = 1'b0;
        r_free       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && l_full && r_full) begin
                    state_d    = LEFT;
                    l_free     = 1'b1;
                    shift_d    = {l_slot[WORD_W-2:0], 1'b0};
                    sd_d       = l_slot[WORD_W-1];
                    in_valid_d = 1'b1;
                    ws_d       = 1'b0;
                    bit_cnt_d  = '1;
                end
            end
            LEFT, RIGHT: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    sd_d      = shift_q[WORD_W-1];
                    shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                end else if (state_q == LEFT) begin
                    state_d   = RIGHT;
                    r_free    = 1'b1;
                    shift_d   = {r_slot[WORD_W-2:0], 1'b0};
                    sd_d      = r_slot[WORD_W-1];
                    ws_d      = 1'b1;
                    bit_cnt_d = '1;
                end else begin
                    state_d      = i2s_pkg::GAP;
                    in_valid_d   = 1'b0;
                    ws_d         = 1'b0;
                    sd_d         = 1'b0;
                    gap_cnt_d    = GAPCNT_W'(GAP - 1);
                    frame_done_d = 1'b1;
                end
            end
            i2s_pkg::GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            in_valid_q   <= 1'b0;
            ws_q         <= 1'b0;
            sd_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            in_valid_q   <= in_valid_d;
            ws_q         <= ws_d;
            sd_q         <= sd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_valid   = in_valid_q;
    assign WS         = ws_q;
    assign SD         = sd_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Bench for i2s_tx_scheduler: frame-timeline reference model, per-cycle output compare,
// serial loopback against accepted samples, and directed literal checks.
module tb_i2s_tx_scheduler;
    localparam int GAP  = 2;
    localparam int FLEN = 64;

    logic        clk = 1'b0;
    logic        rst_n, enable, l_valid, r_valid;
    logic [31:0] l_data, r_data;
    logic        l_ready, r_ready, in_valid, SD, WS, busy, frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2s_tx_scheduler #(.GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .l_valid    (l_valid),
        .l_data     (l_data),
        .l_ready    (l_ready),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .r_ready    (r_ready),
        .in_valid   (in_valid),
        .SD         (SD),
        .WS         (WS),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t is the position inside the frame timeline (-1 = idle,
    // 0..63 serial bits, 64..64+GAP-1 gap cycles).
    bit          m_lf = 0, m_rf = 0, m_lacc = 0, m_racc = 0;
    logic [31:0] m_ld = '0, m_rd = '0;
    logic [63:0] m_frame = '0;
    int          m_t = -1;
    logic [31:0] lq[$];
    logic [31:0] rq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lf = 0; m_rf = 0; m_lacc = 0; m_racc = 0; m_t = -1;
            lq.delete(); rq.delete();
        end else begin
            m_lacc = l_valid && !m_lf;
            m_racc = r_valid && !m_rf;
            if (m_t < 0) begin
                if (enable && m_lf && m_rf) begin
                    m_t = 0;
                    m_frame[63:32] = m_ld;
                    m_lf = 0;
                end
            end else begin
                m_t++;
                if (m_t == 32) begin
                    m_frame[31:0] = m_rd;
                    m_rf = 0;
                end
                if (m_t == FLEN + GAP) m_t = -1;
            end
            if (m_lacc) begin m_lf = 1; m_ld = l_data; lq.push_back(l_data); end
            if (m_racc) begin m_rf = 1; m_rd = r_data; rq.push_back(r_data); end
        end
    end

    function automatic logic [6:0] m_exp();
        logic iv, ws, sd;
        iv = (m_t >= 0) && (m_t < FLEN);
        ws = iv && (m_t >= 32);
        sd = 1'b0;
        if (iv) sd = m_frame[63 - m_t];
        return {iv, ws, sd, (m_t >= 0), (m_t == FLEN), !m_lf, !m_rf};
    endfunction

    always @(negedge clk) begin
        check("cycle{iv,ws,sd,busy,fd,lrdy,rrdy}",
              {in_valid, WS, SD, busy, frame_done, l_ready, r_ready}, m_exp());
    end

    // Serial loopback: rebuild each frame from SD and match it to accepted samples in order.
    logic [63:0] rx_sh = '0;
    int          rx_nb = 0;
    int          rx_frames = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_nb = 0;
        end else if (in_valid) begin
            rx_sh = {rx_sh[62:0], SD};
            rx_nb++;
        end else if (rx_nb != 0) begin
            check("loopback_len", rx_nb, FLEN);
            check("loopback_avail", (lq.size() > 0) && (rq.size() > 0), 1'b1);
            if (lq.size() > 0 && rq.size() > 0)
                check("loopback_pair", rx_sh, {lq.pop_front(), rq.pop_front()});
            rx_frames++;
            rx_nb = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || in_valid) && n < 500) begin @(negedge clk); n++; end
        check("wait_idle_bound", n < 500, 1'b1);
    endtask

    task automatic wait_iv(input logic v, input string name);
        int n = 0;
        while (in_valid !== v && n < 300) begin @(negedge clk); n++; end
        check(name, n < 300, 1'b1);
    endtask

    logic [63:0] sf_exp;
    int          gap_n, base, budget;

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        l_valid = 1'b0; r_valid = 1'b0; l_data = '0; r_data = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {in_valid, WS, SD, busy, frame_done, l_ready, r_ready}, 7'b0000011);
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);

        // Single frame with literal bit pattern
        l_valid = 1'b1; l_data = 32'h8000_0001;
        r_valid = 1'b1; r_data = 32'hA5A5_5A5A;
        @(negedge clk);
        l_valid = 1'b0; r_valid = 1'b0;
        check("sf_launch_pending", {in_valid, l_ready, r_ready}, 3'b000);
        @(negedge clk);
        sf_exp = 64'h8000_0001_A5A5_5A5A;
        for (int i = 0; i < FLEN; i++) begin
            check("sf_bit{iv,ws,sd}", {in_valid, WS, SD}, {1'b1, (i >= 32), sf_exp[63 - i]});
            if (i == 0)  check("sf_ready_left", {l_ready, r_ready}, 2'b10);
            if (i == 32) check("sf_ready_right", r_ready, 1'b1);
            @(negedge clk);
        end
        check("sf_done", {in_valid, frame_done, busy}, 3'b011);
        @(negedge clk);
        check("sf_done_clear", frame_done, 1'b0);

        // Back-to-back with refill during the frame
        wait_idle();
        l_valid = 1'b1; l_data = $urandom; r_valid = 1'b1; r_data = $urandom;
        @(negedge clk);
        l_valid = 1'b0; r_valid = 1'b0;
        wait_iv(1'b1, "b2b_start_bound");
        l_valid = 1'b1; l_data = $urandom;
        @(negedge clk);
        l_valid = 1'b0;
        check("b2b_lready_fall", l_ready, 1'b0);
        repeat (31) @(negedge clk);
        r_valid = 1'b1; r_data = $urandom;
        @(negedge clk);
        r_valid = 1'b0;
        check("b2b_rready_fall", r_ready, 1'b0);
        wait_iv(1'b0, "b2b_end_bound");
        gap_n = 0;
        while (!in_valid && gap_n < 50) begin gap_n++; @(negedge clk); end
        check("b2b_gap_cycles", gap_n, GAP + 1);

        // Enable drop at bit 10 of LEFT with the next pair buffered
        l_valid = 1'b1; l_data = $urandom;
        @(negedge clk);
        l_valid = 1'b0;
        repeat (9) @(negedge clk);
        enable = 1'b0;
        repeat (22) @(negedge clk);
        r_valid = 1'b1; r_data = $urandom;
        @(negedge clk);
        r_valid = 1'b0;
        wait_iv(1'b0, "en_frame_end_bound");
        for (int i = 0; i < 10; i++) begin
            check("en_no_launch", in_valid, 1'b0);
            @(negedge clk);
        end
        check("en_held_state", {busy, l_ready, r_ready}, 3'b000);
        enable = 1'b1;
        @(negedge clk);
        check("en_relaunch", {in_valid, WS}, 2'b10);

        // Reset mid-RIGHT with a left sample buffered
        l_valid = 1'b1; l_data = $urandom;
        @(negedge clk);
        l_valid = 1'b0;
        repeat (39) @(negedge clk);
        check("rst_pre_right", {in_valid, WS}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {in_valid, SD, WS, busy, frame_done, l_ready, r_ready}, 7'b0000011);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_no_launch", {in_valid, busy, l_ready, r_ready}, 4'b0011);
        end

        // Late right sample
        l_valid = 1'b1; l_data = $urandom;
        @(negedge clk);
        l_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("late_wait", {in_valid, l_ready}, 2'b00);
            @(negedge clk);
        end
        r_valid = 1'b1; r_data = $urandom;
        @(negedge clk);
        r_valid = 1'b0;
        check("late_pending", in_valid, 1'b0);
        @(negedge clk);
        check("late_launch", in_valid, 1'b1);
        wait_iv(1'b0, "late_end_bound");

        // Randomized traffic: 100 stereo pairs through the loopback
        base = rx_frames;
        budget = 0;
        while (rx_frames < base + 100 && budget < 40000) begin
            if (l_valid && m_lacc) l_valid = 1'b0;
            if (r_valid && m_racc) r_valid = 1'b0;
            if (!l_valid && $urandom_range(0, 3) == 0) begin l_valid = 1'b1; l_data = $urandom; end
            if (!r_valid && $urandom_range(0, 3) == 0) begin r_valid = 1'b1; r_data = $urandom; end
            enable = ($urandom_range(0, 15) != 0);
            @(negedge clk);
            budget++;
        end
        check("rand_frame_count", rx_frames - base >= 100, 1'b1);
        l_valid = 1'b0; r_valid = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
